// File: rtl/dsm_pkg.sv
// Shared constants and helpers for the multi-channel sigma-delta DAC:
// mode encodings, integrator widths, saturation bounds and feedback magnitude.
package dsm_pkg;

  localparam logic ORDER1 = 1'b0;
  localparam logic ORDER2 = 1'b1;

  localparam int I1_GUARD = 2;
  localparam int I2_GUARD = 4;

  function automatic int i1_width(input int bw);
    return bw + I1_GUARD;
  endfunction

  function automatic int i2_width(input int bw);
    return bw + I2_GUARD;
  endfunction

  // i1 clamps to its full width; i2 keeps one spare bit above its clamp range.
  function automatic longint i1_lim(input int bw);
    return longint'(1) << (bw + 1);
  endfunction

  function automatic longint i2_lim(input int bw);
    return longint'(1) << (bw + 2);
  endfunction

  function automatic longint fb_mag(input int bw);
    return longint'(1) << (bw - 1);
  endfunction

endpackage

// File: rtl/dsm_channel.sv
// One 1-bit sigma-delta modulator, first or second order, with saturating
// integrators. Cleared by reset, by a mode change (clr) and while disabled.
module dsm_channel
  import dsm_pkg::*;
#(
  parameter int BW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 order2,
  input  logic signed [BW-1:0] x,
  output logic                 dac_bit
);

  localparam int W1 = i1_width(BW);
  localparam int W2 = i2_width(BW);
  // Working width holds any unclamped sum without wrapping.
  localparam int WS = W2 + 1;
  localparam logic signed [WS-1:0] FB = WS'(fb_mag(BW));

  logic signed [W1-1:0] i1;
  logic signed [W2-1:0] i2;
  logic signed [WS-1:0] fb, i1_sum, i1_nx, i2_sum, i2_nx;

  function automatic logic signed [WS-1:0] sat(input logic signed [WS-1:0] v,
                                               input longint lim);
    logic signed [WS-1:0] hi, lo;
    hi = WS'(lim - 1);
    lo = WS'(-lim);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  always_comb begin
    fb     = dac_bit ? FB : -FB;
    i1_sum = WS'(i1) + WS'(x) - fb;
    i1_nx  = sat(i1_sum, i1_lim(BW));
    i2_sum = WS'(i2) + i1_nx - fb;
    i2_nx  = sat(i2_sum, i2_lim(BW));
  end

  // Integrator / quantiser stage
  always_ff @(posedge clk) begin
    if (!rst_n || clr || !en) begin
      i1      <= '0;
      i2      <= '0;
      dac_bit <= 1'b0;
    end else begin
      i1      <= W1'(i1_nx);
      i2      <= (order2 == ORDER2) ? W2'(i2_nx) : '0;
      dac_bit <= (order2 == ORDER1) ? ~i1_nx[WS-1] : ~i2_nx[WS-1];
    end
  end

endmodule

// File: rtl/dsm_dac_multi.sv
// Multi-channel sigma-delta DAC top: one-deep frame handshake, zero-order hold
// over a programmable frame period, and one modulator per channel.
module dsm_dac_multi
  import dsm_pkg::*;
#(
  parameter int BW    = 16,
  parameter int CH    = 2,
  parameter int OSR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              order2_i,
  input  logic [OSR_W-1:0]  osr_i,
  input  logic [CH*BW-1:0]  sample_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [CH-1:0]     dac_o,
  output logic              tick_o,
  output logic              underrun_o
);

  logic             hold_full;
  logic [CH*BW-1:0] hold;
  logic [CH*BW-1:0] active;
  logic [OSR_W-1:0] cnt;
  logic             order_q;
  logic             wrap, xfer, clr;

  assign ready_o = rst_n & ~hold_full;
  assign xfer    = valid_i & ready_o;
  assign wrap    = en & (cnt == osr_i);
  assign clr     = order2_i ^ order_q;

  // Frame timing and hold/active buffering stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_full  <= 1'b0;
      hold       <= '0;
      active     <= '0;
      cnt        <= '0;
      tick_o     <= 1'b0;
      underrun_o <= 1'b0;
      order_q    <= order2_i;
    end else begin
      order_q    <= order2_i;
      tick_o     <= wrap;
      underrun_o <= wrap & ~hold_full;
      if (en) cnt <= wrap ? '0 : cnt + OSR_W'(1);
      // xfer needs an empty buffer, so it never collides with the promote below.
      if (xfer) begin
        hold      <= sample_i;
        hold_full <= 1'b1;
      end
      if (wrap && hold_full) begin
        active    <= hold;
        hold_full <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    dsm_channel #(.BW(BW)) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .clr    (clr),
      .order2 (order_q),
      .x      ($signed(active[k*BW +: BW])),
      .dac_bit(dac_o[k])
    );
  end

endmodule
